main_memory_responder: RTL

- Synthesizable main-memory model for the memory side of the direct-mapped cache controller's M-bus (MAddress/MStrobe/MRW/MData_Out in, MData_In/MReady out).
- Accepts one word read or write per strobe, waits a programmable latency, then completes with a one-cycle MReady pulse.
- Replaces the ad-hoc behavioural memory used in cache benches and serves as the memory stub in integration.
- Read data is held stable until the next accepted read.

---
 rtl/main_memory_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// Purpose: word-wide main-memory model answering the cache controller's M-bus with a fixed-latency MReady pulse.
// Latency: a request accepted at edge E0 completes with MReady high in the cycle after edge E0+LATENCY.
// Backpressure: one request at a time; a held MStrobe is parked in RELEASE until it drops, so it never re-triggers.
module main_memory_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] MAddress,
    input  logic                  MStrobe,
    input  logic                  MRW,
    input  logic [DATA_WIDTH-1:0] MData_Out,
    output logic [DATA_WIDTH-1:0] MData_In,
    output logic                  MReady,
    output logic                  addr_err
);

    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IW-1:0]           addr_q;
    logic                    oor_q;
    logic                    rw_q;
    logic [DATA_WIDTH-1:0]   wdat_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic                    accept;
    logic                    fire;
    logic                    commit_wr;
    logic                    req_oor;
    logic                    unused_addr_bits;

    // Byte offset bits carry no meaning for a word-wide memory.
    assign unused_addr_bits = ^MAddress[1:0];

    // Any address bit above the word-index field points outside the array.
    generate
        if (ADDR_WIDTH > IW + 2) begin : g_oor
            assign req_oor = |MAddress[ADDR_WIDTH-1:IW+2];
        end else begin : g_no_oor
            assign req_oor = 1'b0;
        end
    endgenerate

    assign accept    = (state_q == IDLE) && MStrobe;
    // fire marks the edge that moves BUSY into RESP: data is read or committed here.
    assign fire      = (state_q == BUSY) && (cnt_q == 4'd0);
    assign commit_wr = fire && !rw_q && !oor_q;

    // State, latency counter, latched request and sticky status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            rw_q    <= 1'b0;
            wdat_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= MAddress[IW+1:2];
                oor_q  <= req_oor;
                rw_q   <= MRW;
                wdat_q <= MData_Out;
            end
            if (fire && rw_q) begin
                rdata_q <= oor_q ? '1 : mem_q[addr_q];
            end
            if (fire && oor_q) begin
                err_q <= 1'b1;
            end
        end
    end

    // Array write; reset holds the FSM out of BUSY so a pending write cannot land.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem_q[addr_q] <= wdat_q;
        end
    end

    // Next-state and counter decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (MStrobe) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!MStrobe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign MReady   = (state_q == RESP);
    assign MData_In = rdata_q;
    assign addr_err = err_q;

endmodule
